// File: rtl/bridge_buffer_pkg.sv
// Shared definitions for the bridge buffer controller.
//   - state_e    : controller FSM states
//   - IdxMaxW    : storage width of the tile indices (upper bound on slice counts)
//   - PipeW      : width of the {valid, first, last} framing bundle
//   - width_for(): clog2 that never returns zero, for sizing counters and selects
//   - tile_idx_t : current (west slice, north slice) tile pair
package bridge_buffer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StWaitSa,
    StStream,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned MaxModules = 256;
  localparam int unsigned IdxMaxW    = $clog2(MaxModules);
  localparam int unsigned PipeW      = 3;

  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [IdxMaxW-1:0] w_idx;
    logic [IdxMaxW-1:0] n_idx;
  } tile_idx_t;

endpackage

// File: rtl/bridge_valid_pipe.sv
// Fixed-latency shift register for read framing. It delays an arbitrary bundle
// (here {valid, first, last}) by Depth cycles so the bundle lines up with the
// buffer port-B dout.
//   clk, rst_n : clock, asynchronous active-low reset (clears every stage)
//   in_data    : bundle launched alongside the read enable
//   out_data   : bundle delayed by Depth cycles
module bridge_valid_pipe
  import bridge_buffer_pkg::*;
#(
  parameter int unsigned Width = PipeW,
  parameter int unsigned Depth = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] in_data,
  output logic [Width-1:0] out_data
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_data;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_data = stage_q[Depth-1];

endmodule

// File: rtl/bridge_buffer_ctrl.sv
// Control FSM for the west/north bridge buffer pair. It fills both buffers from
// the linear-projection stream, then replays every (west slice, north slice)
// tile pair to the systolic array with beat framing.
//   clk, rst_n             : clock, asynchronous active-low reset
//   start                  : begin one fill+replay pass (honoured only in idle)
//   w/n_in_valid/ready     : write-side handshakes, one word per fire
//   w/n_bank0_ena/wea/addra: port-A write controls (ena and wea tied together)
//   w/n_bank0_enb/addrb    : port-B read controls
//   w/n_slicing_idx        : slice select for the buffer output muxes
//   sa_ready               : array can take the next tile
//   sa_valid/first/last    : dout framing, aligned to the read latency
//   busy, done             : pass in progress / one-cycle end-of-pass pulse
module bridge_buffer_ctrl
  import bridge_buffer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned TOTAL_DEPTH     = 12,
  parameter int unsigned W_TOTAL_MODULES = 4,
  parameter int unsigned N_TOTAL_MODULES = 4,
  parameter int unsigned RD_LAT          = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  w_in_valid,
  output logic                                  w_in_ready,
  input  logic                                  n_in_valid,
  output logic                                  n_in_ready,
  output logic                                  w_bank0_ena,
  output logic                                  w_bank0_wea,
  output logic [ADDR_WIDTH-1:0]                 w_bank0_addra,
  output logic                                  w_bank0_enb,
  output logic [ADDR_WIDTH-1:0]                 w_bank0_addrb,
  output logic                                  n_bank0_ena,
  output logic                                  n_bank0_wea,
  output logic [ADDR_WIDTH-1:0]                 n_bank0_addra,
  output logic                                  n_bank0_enb,
  output logic [ADDR_WIDTH-1:0]                 n_bank0_addrb,
  output logic [width_for(W_TOTAL_MODULES)-1:0] w_slicing_idx,
  output logic [width_for(N_TOTAL_MODULES)-1:0] n_slicing_idx,
  input  logic                                  sa_ready,
  output logic                                  sa_valid,
  output logic                                  sa_first,
  output logic                                  sa_last,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned CntW   = width_for(TOTAL_DEPTH + 1);
  localparam int unsigned WIdxW  = width_for(W_TOTAL_MODULES);
  localparam int unsigned NIdxW  = width_for(N_TOTAL_MODULES);
  localparam int unsigned DrainW = width_for(RD_LAT);

  if (TOTAL_DEPTH > (2 ** ADDR_WIDTH)) begin : gen_depth_chk
    $error("TOTAL_DEPTH does not fit in ADDR_WIDTH address bits");
  end
  if (RD_LAT < 1) begin : gen_lat_chk
    $error("RD_LAT must be at least 1");
  end
  if (W_TOTAL_MODULES > MaxModules || N_TOTAL_MODULES > MaxModules) begin : gen_mod_chk
    $error("slice count exceeds tile index storage");
  end

  state_e           state_q, state_d;
  logic [CntW-1:0]  w_wcnt_q, w_wcnt_d;
  logic [CntW-1:0]  n_wcnt_q, n_wcnt_d;
  logic [CntW-1:0]  k_q, k_d;
  logic [DrainW-1:0] drain_q, drain_d;
  tile_idx_t        tile_q, tile_d;
  logic             busy_q;

  logic w_fire, n_fire;
  logic rd_en, rd_first, rd_last;
  logic [PipeW-1:0] frame_out;

  assign w_in_ready = (state_q == StFill) && (w_wcnt_q < CntW'(TOTAL_DEPTH));
  assign n_in_ready = (state_q == StFill) && (n_wcnt_q < CntW'(TOTAL_DEPTH));
  assign w_fire     = w_in_valid && w_in_ready;
  assign n_fire     = n_in_valid && n_in_ready;

  assign rd_en    = (state_q == StStream);
  assign rd_first = rd_en && (k_q == '0);
  assign rd_last  = rd_en && (k_q == CntW'(TOTAL_DEPTH - 1));

  always_comb begin
    state_d  = state_q;
    w_wcnt_d = w_wcnt_q;
    n_wcnt_d = n_wcnt_q;
    k_d      = k_q;
    drain_d  = drain_q;
    tile_d   = tile_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StFill;
          w_wcnt_d = '0;
          n_wcnt_d = '0;
          tile_d   = '0;
        end
      end

      StFill: begin
        if (w_fire) w_wcnt_d = w_wcnt_q + CntW'(1);
        if (n_fire) n_wcnt_d = n_wcnt_q + CntW'(1);
        // Leave as soon as the final word of the later side lands.
        if (w_wcnt_d == CntW'(TOTAL_DEPTH) && n_wcnt_d == CntW'(TOTAL_DEPTH)) begin
          state_d = StWaitSa;
        end
      end

      StWaitSa: begin
        if (sa_ready) begin
          state_d = StStream;
          k_d     = '0;
        end
      end

      StStream: begin
        if (k_q == CntW'(TOTAL_DEPTH - 1)) begin
          state_d = StDrain;
          k_d     = '0;
          drain_d = '0;
        end else begin
          k_d = k_q + CntW'(1);
        end
      end

      StDrain: begin
        // Indices are held until the last in-flight beat has left the buffers.
        if (drain_q == DrainW'(RD_LAT - 1)) begin
          state_d = StWaitSa;
          if (tile_q.n_idx == IdxMaxW'(N_TOTAL_MODULES - 1)) begin
            tile_d.n_idx = '0;
            if (tile_q.w_idx == IdxMaxW'(W_TOTAL_MODULES - 1)) begin
              tile_d.w_idx = '0;
              state_d      = StDone;
            end else begin
              tile_d.w_idx = tile_q.w_idx + IdxMaxW'(1);
            end
          end else begin
            tile_d.n_idx = tile_q.n_idx + IdxMaxW'(1);
          end
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
        tile_d  = '0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      w_wcnt_q <= '0;
      n_wcnt_q <= '0;
      k_q      <= '0;
      drain_q  <= '0;
      tile_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_wcnt_q <= w_wcnt_d;
      n_wcnt_q <= n_wcnt_d;
      k_q      <= k_d;
      drain_q  <= drain_d;
      tile_q   <= tile_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  bridge_valid_pipe #(
    .Width(PipeW),
    .Depth(RD_LAT)
  ) u_valid_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data ({rd_en, rd_first, rd_last}),
    .out_data(frame_out)
  );

  assign w_bank0_ena   = w_fire;
  assign w_bank0_wea   = w_fire;
  assign w_bank0_addra = w_fire ? ADDR_WIDTH'(w_wcnt_q) : '0;
  assign n_bank0_ena   = n_fire;
  assign n_bank0_wea   = n_fire;
  assign n_bank0_addra = n_fire ? ADDR_WIDTH'(n_wcnt_q) : '0;

  assign w_bank0_enb   = rd_en;
  assign n_bank0_enb   = rd_en;
  assign w_bank0_addrb = rd_en ? ADDR_WIDTH'(k_q) : '0;
  assign n_bank0_addrb = rd_en ? ADDR_WIDTH'(k_q) : '0;

  assign w_slicing_idx = tile_q.w_idx[WIdxW-1:0];
  assign n_slicing_idx = tile_q.n_idx[NIdxW-1:0];

  assign sa_valid = frame_out[2];
  assign sa_first = frame_out[1];
  assign sa_last  = frame_out[0];

  assign busy = busy_q;
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_bridge_buffer_ctrl.sv
// Bench for bridge_buffer_ctrl: two instances (read latency 1 and 3) share the
// stimulus. Each has a scoreboard of expected tiles and delayed framing beats.
module tb_bridge_buffer_ctrl;

  localparam int Depth = 12;
  localparam int WMods = 4;
  localparam int NMods = 4;

  logic clk = 1'b0;
  logic rst_n, start, w_in_valid, n_in_valid, sa_ready;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int w;
    int n;
  } tile_t;

  typedef struct {
    int due;
    bit first;
    bit last;
  } beat_t;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int RdLat = (g == 0) ? 1 : 3;
    string pfx = (g == 0) ? "lat1" : "lat3";

    logic       w_in_ready, n_in_ready, w_ena, w_wea, n_ena, n_wea, w_enb, n_enb;
    logic       sa_valid, sa_first, sa_last, busy, done;
    logic [7:0] w_addra, w_addrb, n_addra, n_addrb;
    logic [1:0] w_sl, n_sl;

    bridge_buffer_ctrl #(
      .ADDR_WIDTH     (8),
      .TOTAL_DEPTH    (Depth),
      .W_TOTAL_MODULES(WMods),
      .N_TOTAL_MODULES(NMods),
      .RD_LAT         (RdLat)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .w_in_valid   (w_in_valid),
      .w_in_ready   (w_in_ready),
      .n_in_valid   (n_in_valid),
      .n_in_ready   (n_in_ready),
      .w_bank0_ena  (w_ena),
      .w_bank0_wea  (w_wea),
      .w_bank0_addra(w_addra),
      .w_bank0_enb  (w_enb),
      .w_bank0_addrb(w_addrb),
      .n_bank0_ena  (n_ena),
      .n_bank0_wea  (n_wea),
      .n_bank0_addra(n_addra),
      .n_bank0_enb  (n_enb),
      .n_bank0_addrb(n_addrb),
      .w_slicing_idx(w_sl),
      .n_slicing_idx(n_sl),
      .sa_ready     (sa_ready),
      .sa_valid     (sa_valid),
      .sa_first     (sa_first),
      .sa_last      (sa_last),
      .busy         (busy),
      .done         (done)
    );

    tile_t exp_tiles[$];
    beat_t exp_beats[$];
    int    ncyc = 0;
    int    w_cnt = 0, n_cnt = 0, k = 0, tiles_done = 0;
    int    last_end = 0, last_fill = 0, done_cnt = 0;
    bit    pass_active = 0, go = 0, fill = 0, bp = 0;

    always @(negedge clk) begin
      bit exp_wf, exp_nf, exp_v;
      ncyc++;
      if (!rst_n) begin
        exp_tiles.delete();
        exp_beats.delete();
        pass_active = 0;
        go = 0;
        fill = 0;
        bp = 0;
        k = 0;
        tiles_done = 0;
        w_cnt = 0;
        n_cnt = 0;
      end else begin
        check({pfx, "_busy"}, busy, pass_active);
        if (done) begin
          check({pfx, "_done_tiles"}, tiles_done, WMods * NMods);
          check({pfx, "_done_lat"}, ncyc - last_end, RdLat + 1);
          done_cnt++;
          pass_active = 0;
        end

        // Fill side
        if (go) begin
          fill = 1;
          w_cnt = 0;
          n_cnt = 0;
          go = 0;
        end
        check({pfx, "_w_ready"}, w_in_ready, fill && w_cnt < Depth);
        check({pfx, "_n_ready"}, n_in_ready, fill && n_cnt < Depth);
        exp_wf = w_in_valid && fill && w_cnt < Depth;
        exp_nf = n_in_valid && fill && n_cnt < Depth;
        check({pfx, "_w_ena"}, {w_ena, w_wea}, {exp_wf, exp_wf});
        check({pfx, "_n_ena"}, {n_ena, n_wea}, {exp_nf, exp_nf});
        if (exp_wf) begin
          check({pfx, "_w_addra"}, w_addra, w_cnt);
          w_cnt++;
        end
        if (exp_nf) begin
          check({pfx, "_n_addra"}, n_addra, n_cnt);
          n_cnt++;
        end
        if (fill && w_cnt == Depth && n_cnt == Depth) begin
          fill = 0;
          last_fill = ncyc;
        end

        // Replay side
        if (k != 0) check({pfx, "_no_stall"}, w_enb, 1);
        if (w_enb) begin
          check({pfx, "_n_enb"}, n_enb, 1);
          if (exp_tiles.size() == 0) begin
            check({pfx, "_unexp_rd"}, w_enb, 0);
          end else begin
            if (k == 0) begin
              if (tiles_done == 0) check({pfx, "_fill_to_rd"}, ncyc - last_fill, 2);
              else if (bp) check({pfx, "_gap_min"}, (ncyc - last_end - 1) >= RdLat + 1, 1);
              else check({pfx, "_gap"}, ncyc - last_end - 1, RdLat + 1);
            end
            check({pfx, "_w_addrb"}, w_addrb, k);
            check({pfx, "_n_addrb"}, n_addrb, k);
            check({pfx, "_w_idx"}, w_sl, exp_tiles[0].w);
            check({pfx, "_n_idx"}, n_sl, exp_tiles[0].n);
            exp_beats.push_back('{ncyc + RdLat, k == 0, k == Depth - 1});
            k++;
            if (k == Depth) begin
              k = 0;
              void'(exp_tiles.pop_front());
              tiles_done++;
              last_end = ncyc;
              bp = 0;
            end
          end
        end else begin
          check({pfx, "_n_enb_off"}, n_enb, 0);
          if (!sa_ready) bp = 1;
          if (!sa_ready && tiles_done > 0 && exp_tiles.size() > 0 && ncyc - last_end > RdLat) begin
            check({pfx, "_hold_idx"}, {w_sl, n_sl}, {2'(exp_tiles[0].w), 2'(exp_tiles[0].n)});
          end
        end

        exp_v = exp_beats.size() > 0 && exp_beats[0].due == ncyc;
        check({pfx, "_sa_valid"}, sa_valid, exp_v);
        if (exp_v) begin
          check({pfx, "_sa_fl"}, {sa_first, sa_last}, {exp_beats[0].first, exp_beats[0].last});
          void'(exp_beats.pop_front());
        end

        if (start && !pass_active) begin
          pass_active = 1;
          go = 1;
          tiles_done = 0;
          k = 0;
          exp_tiles.delete();
          for (int wi = 0; wi < WMods; wi++) begin
            for (int ni = 0; ni < NMods; ni++) exp_tiles.push_back('{wi, ni});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_lat1_outs"},
          {gen_dut[0].busy, gen_dut[0].done, gen_dut[0].w_enb, gen_dut[0].n_enb,
           gen_dut[0].sa_valid, gen_dut[0].sa_first, gen_dut[0].sa_last,
           gen_dut[0].w_in_ready, gen_dut[0].n_in_ready, gen_dut[0].w_ena,
           gen_dut[0].n_ena, gen_dut[0].w_sl, gen_dut[0].n_sl}, 0);
    check({tag, "_lat3_outs"},
          {gen_dut[1].busy, gen_dut[1].done, gen_dut[1].w_enb, gen_dut[1].n_enb,
           gen_dut[1].sa_valid, gen_dut[1].sa_first, gen_dut[1].sa_last,
           gen_dut[1].w_in_ready, gen_dut[1].n_in_ready, gen_dut[1].w_ena,
           gen_dut[1].n_ena, gen_dut[1].w_sl, gen_dut[1].n_sl}, 0);
  endtask

  task automatic start_pass();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    w_in_valid = 1'b0;
    n_in_valid = 1'b0;
    sa_ready   = 1'b1;
    repeat (3) step();
    check_quiet("reset");
    rst_n = 1'b1;
    step();

    // Pass 1: west every cycle, north every other cycle, stray start in fill
    start_pass();
    for (int i = 0; i < 30; i++) begin
      w_in_valid = 1'b1;
      n_in_valid = (i % 2 == 0);
      start      = (i == 3);
      step();
    end
    w_in_valid = 1'b0;
    n_in_valid = 1'b0;
    start      = 1'b0;

    for (int t = 0; t < 500 && !(gen_dut[0].tiles_done == 2 && gen_dut[0].k == 6); t++) step();
    check("wait_stream", gen_dut[0].tiles_done == 2 && gen_dut[0].k == 6, 1);
    start_pass();

    for (int t = 0; t < 500 && gen_dut[0].tiles_done != 5; t++) step();
    check("wait_tile5", gen_dut[0].tiles_done, 5);
    sa_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 1) begin
        check("bp_enb", gen_dut[0].w_enb, 0);
        check("bp_idx", {gen_dut[0].w_sl, gen_dut[0].n_sl}, 4'b0101);
      end
    end
    sa_ready = 1'b1;

    for (int t = 0; t < 3000 && !(gen_dut[0].done_cnt >= 1 && gen_dut[1].done_cnt >= 1); t++)
      step();
    check("pass1_done", gen_dut[0].done_cnt + gen_dut[1].done_cnt, 2);

    // Pass 2: aborted by reset in tile 7, beat 4
    step();
    start_pass();
    w_in_valid = 1'b1;
    n_in_valid = 1'b1;
    repeat (14) step();
    w_in_valid = 1'b0;
    n_in_valid = 1'b0;
    for (int t = 0; t < 2000 && !(gen_dut[0].tiles_done == 7 && gen_dut[0].k == 4); t++) step();
    check("wait_t7b4", gen_dut[0].tiles_done == 7 && gen_dut[0].k == 4, 1);
    rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Pass 3: clean pass after the abort
    start_pass();
    w_in_valid = 1'b1;
    n_in_valid = 1'b1;
    repeat (14) step();
    w_in_valid = 1'b0;
    n_in_valid = 1'b0;
    for (int t = 0; t < 3000 && !(gen_dut[0].done_cnt >= 2 && gen_dut[1].done_cnt >= 2); t++)
      step();
    repeat (3) step();
    check("lat1_done_cnt", gen_dut[0].done_cnt, 2);
    check("lat3_done_cnt", gen_dut[1].done_cnt, 2);
    check("lat1_idle", gen_dut[0].busy, 0);
    check("lat3_idle", gen_dut[1].busy, 0);
    check("lat1_tiles_left", gen_dut[0].exp_tiles.size(), 0);
    check("lat3_tiles_left", gen_dut[1].exp_tiles.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bridge_buffer_ctrl.md
Name: bridge_buffer_ctrl

Overview:
Control FSM for the bridge buffer pair (west and north) between linear projection and the systolic array. It produces every control signal the buffers consume: port-A write enables and addresses, port-B read enables and addresses, and slicing_idx. It fills both buffers from the linear-projection stream, then replays every (west slice, north slice) tile pair to the systolic array. It also generates the beat-valid and tile framing that the array uses.

Parameters:
ADDR_WIDTH, 8, address width of both buffer banks
TOTAL_DEPTH, 12, words written per buffer and beats read per tile
W_TOTAL_MODULES, 4, west slice count (outer tile loop)
N_TOTAL_MODULES, 4, north slice count (inner tile loop)
RD_LAT, 1, buffer port-B read latency in cycles (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse to begin one fill+replay pass
w_in_valid  in  1  west write word valid
w_in_ready  out  1  west write accept
n_in_valid  in  1  north write word valid
n_in_ready  out  1  north write accept
w_bank0_ena/wea  out  1  west port-A enable/write (tied equal)
w_bank0_addra  out  ADDR_WIDTH  west write address
w_bank0_enb  out  1  west read enable
w_bank0_addrb  out  ADDR_WIDTH  west read address
n_bank0_ena/wea/addra/enb/addrb  out  1/1/ADDR_WIDTH/1/ADDR_WIDTH  north equivalents
w_slicing_idx  out  clog2(W_TOTAL_MODULES)  west slice select
n_slicing_idx  out  clog2(N_TOTAL_MODULES)  north slice select
sa_ready  in  1  systolic array ready for next tile
sa_valid  out  1  buffer dout valid this cycle
sa_first  out  1  first beat of tile, qualified by sa_valid
sa_last  out  1  last beat of tile, qualified by sa_valid
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (async): state=IDLE. All outputs 0, all counters 0. Reset mid-pass aborts the pass with no done pulse.
- States: IDLE, FILL, WAIT_SA, STREAM, DRAIN, DONE.
- IDLE: start -> FILL. start is ignored in all other states.
- FILL:
  - Independent counters w_wcnt and n_wcnt.
  - w_in_ready = (w_wcnt < TOTAL_DEPTH). Write fires when w_in_valid && w_in_ready.
  - On a write: w_bank0_ena=wea=1, addra=w_wcnt, w_wcnt++. Combinational with the handshake.
  - North side is identical.
  - The two sides may complete in either order or in the same cycle.
  - Exit to WAIT_SA on the cycle after both counters reach TOTAL_DEPTH. Ready is 0 once a side is full.
- WAIT_SA: slicing indices are held. Move to STREAM when sa_ready=1.
- STREAM: exactly TOTAL_DEPTH cycles, with no stall.
  - enb=1 on both banks; addrb=k on both; k counts 0..TOTAL_DEPTH-1.
  - Exit to DRAIN after k=TOTAL_DEPTH-1.
- DRAIN: RD_LAT cycles with enb=0. Then advance the tile:
  - n_idx++.
  - On n_idx wrap (N_TOTAL_MODULES-1 -> 0): w_idx++.
  - If both wrap -> DONE, else -> WAIT_SA.
- Slicing indices stay stable from WAIT_SA through the end of DRAIN, covering the output-mux latency.
- Output framing:
  - sa_valid = enb delayed by RD_LAT cycles.
  - sa_first = (enb && k==0) delayed by RD_LAT.
  - sa_last = (enb && k==TOTAL_DEPTH-1) delayed by RD_LAT.
  - Each tile yields exactly TOTAL_DEPTH valid beats.
- DONE: done=1 for one cycle, indices reset to 0 -> IDLE.
- busy is registered: 1 in all states other than IDLE.
- Pass length: W_TOTAL_MODULES*N_TOTAL_MODULES tiles.
- Counter widths: wide enough to hold TOTAL_DEPTH, i.e. clog2(TOTAL_DEPTH+1).
- Elaboration check: TOTAL_DEPTH <= 2**ADDR_WIDTH.

Decomposition:
- Shared package bridge_buffer_pkg holds:
  - state enum typedef;
  - clog2-derived width localparams;
  - a tile-index struct {w_idx, n_idx}.
- One sub-module, bridge_valid_pipe: an RD_LAT-deep shift register carrying {valid, first, last}. It is reusable wherever the buffer read latency must be matched.

Test Plan:
- Reset and fill: reset, start, west valid constant, north valid alternating every other cycle. Expect 12 west writes at addra 0..11 and 12 north writes at addra 0..11. Ready drops after the 12th write on each side; WAIT_SA is entered one cycle after the later side completes.
- Full replay: sa_ready=1 throughout, defaults. Expect 16 tiles with (w,n) order (0,0),(0,1)..(3,3). Each tile gives 12 sa_valid beats, sa_first on beat 0 and sa_last on beat 11, RD_LAT=1 after enb. Expect a single done pulse, then IDLE.
- Backpressure: hold sa_ready=0 for 20 cycles after tile 5. Expect the FSM to sit in WAIT_SA with indices (1,1) stable and enb=0, then resume the stream unchanged.
- Latency parameter: RD_LAT=3. sa_valid must lag enb by exactly 3 cycles. DRAIN lasts 3 cycles, and no valid beat may overlap the next tile.
- Reset mid-stream: assert rst_n=0 during tile 7 beat 4. Outputs go to 0 immediately, done never pulses, and a new start runs a full clean pass.
- Ignored start: pulse start during FILL and during STREAM. Expect no change in counters, state, or tile order.
